// File: rtl/tpu_pkg.sv
// Shared types and constants for the accumulator drain / bf16 conversion path.
package tpu_pkg;

    localparam int ACC_W     = 18;
    localparam int BF16_W    = 16;
    localparam int BF16_BIAS = 127;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_t;

endpackage

// File: rtl/int18_to_bf16_lzd.sv
// Signed 18-bit fixed-point to bf16 converter.
// Sign-magnitude with a leading-zero normalizer and a truncated 7-bit mantissa.
module int18_to_bf16_lzd
    import tpu_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [BF16_W-1:0] bf16
);

    localparam int LEAD_W = $clog2(ACC_W);
    localparam logic signed [11:0] EXP_OFF = 12'(BF16_BIAS - FRAC_BITS);

    logic                     sign;
    logic [ACC_W-1:0]         mag;
    logic [LEAD_W-1:0]        lead;
    logic signed [11:0]       exp_s;
    logic [ACC_W-1:0]         norm;
    logic [6:0]               mant;

    // Magnitude, leading-one position, biased exponent and normalized mantissa.
    // The magnitude is kept unsigned so -2^17 converts to 2^17 without overflow.
    always_comb begin
        sign  = acc[ACC_W-1];
        mag   = sign ? (~acc + 1'b1) : acc;
        lead  = '0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            if (mag[i]) begin
                lead = LEAD_W'(i);
            end
        end
        exp_s = $signed({7'd0, lead}) + EXP_OFF;
        norm  = mag << (LEAD_W'(ACC_W - 1) - lead);
        mant  = 7'(norm >> (ACC_W - 1 - 7));
        if (mag == '0) begin
            bf16 = '0;
        end else if (exp_s <= 12'sd0) begin
            bf16 = {sign, 15'd0};
        end else if (exp_s >= 12'sd255) begin
            bf16 = {sign, 8'hFF, 7'd0};
        end else begin
            bf16 = {sign, exp_s[7:0], mant};
        end
    end

endmodule

// File: rtl/bf16_drain_sequencer.sv
// Drains one bank of signed accumulators lane by lane through a shared
// bf16 converter onto a registered valid/ready output stream.
module bf16_drain_sequencer
    import tpu_pkg::*;
#(
    parameter  int N_LANES   = 4,
    parameter  int FRAC_BITS = 8,
    localparam int LANE_W    = $clog2(N_LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  logic [ACC_W*N_LANES-1:0] acc_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BF16_W-1:0]        out_bf16,
    output logic [LANE_W-1:0]        out_lane,
    output logic                     out_last,
    output logic                     busy
);

    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(N_LANES - 1);

    drain_state_t               state;
    logic [LANE_W-1:0]          idx;
    logic [ACC_W*N_LANES-1:0]   bank_buf;
    logic [ACC_W-1:0]           cur_acc;
    logic [BF16_W-1:0]          cur_bf16;
    logic                       adv;

    // Handshake and status flags derived from the FSM and output register.
    always_comb begin
        acc_ready = (state == IDLE);
        busy      = (state == DRAIN) || out_valid;
        adv       = !out_valid || out_ready;
        cur_acc   = bank_buf[ACC_W*idx +: ACC_W];
    end

    int18_to_bf16_lzd #(
        .FRAC_BITS(FRAC_BITS)
    ) u_conv (
        .acc  (cur_acc),
        .bf16 (cur_bf16)
    );

    // FSM, bank buffer and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            bank_buf  <= '0;
            out_valid <= 1'b0;
            out_bf16  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A pending last result retires independently of a new bank load.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (acc_valid) begin
                        bank_buf <= acc_data;
                        idx      <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (adv) begin
                        out_bf16  <= cur_bf16;
                        out_lane  <= idx;
                        out_last  <= (idx == LAST_IDX);
                        out_valid <= 1'b1;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_drain_sequencer.sv
// Self-checking bench for bf16_drain_sequencer (N_LANES=4, FRAC_BITS=8).
module tb_bf16_drain_sequencer;

    localparam int N_LANES   = 4;
    localparam int FRAC_BITS = 8;
    localparam int LANE_W    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                acc_valid = 1'b0;
    logic                acc_ready;
    logic [18*N_LANES-1:0] acc_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [15:0]         out_bf16;
    logic [LANE_W-1:0]   out_lane;
    logic                out_last;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bf16_drain_sequencer #(
        .N_LANES  (N_LANES),
        .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_valid(acc_valid),
        .acc_ready(acc_ready),
        .acc_data (acc_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bf16 (out_bf16),
        .out_lane (out_lane),
        .out_last (out_last),
        .busy     (busy)
    );

    // Reference conversion: real-valued scaling to find exponent and truncated mantissa.
    function automatic logic [15:0] ref_bf16(input int a);
        real  r;
        int   e;
        int   mag;
        int   biased;
        int   mant;
        logic s;
        if (a == 0) return 16'h0000;
        s   = (a < 0);
        mag = s ? -a : a;
        r   = real'(mag) / (2.0 ** FRAC_BITS);
        e   = 0;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        biased = e + 127;
        if (biased <= 0)   return {s, 15'h0000};
        if (biased >= 255) return {s, 8'hFF, 7'h00};
        mant = int'($floor((r - 1.0) * 128.0));
        return {s, biased[7:0], mant[6:0]};
    endfunction

    function automatic logic [71:0] pack_bank(input int a0, input int a1, input int a2, input int a3);
        return {a3[17:0], a2[17:0], a1[17:0], a0[17:0]};
    endfunction

    function automatic int lane_val(input logic [71:0] bank, input int i);
        logic signed [17:0] t;
        t = bank[18*i +: 18];
        return int'(t);
    endfunction

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_bf16 !== 16'h0) begin errors++; $display("FAIL reset_out_bf16: got %h expected 0000", out_bf16); end
        checks++; if (out_lane !== '0) begin errors++; $display("FAIL reset_out_lane: got %0d expected 0", out_lane); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready: got %b expected 1", acc_ready); end
    endtask

    // One bank, optional 1,0,0 ready pattern; checks latency, order, hold and acc_ready timing.
    task automatic test_single_bank(input string name, input logic [71:0] bank,
                                    input logic [63:0] expw, input bit stall);
        int cyc;
        int lane;
        int first_cyc;
        logic [15:0] ew;
        @(negedge clk);
        acc_data  = bank;
        acc_valid = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (acc_ready !== 1'b1) begin errors++; $display("FAIL %s_accept: acc_ready got %b expected 1", name, acc_ready); end
        @(negedge clk);
        acc_valid = 1'b0;
        cyc = 1; lane = 0; first_cyc = -1;
        while (lane < 4 && cyc < 40) begin
            out_ready = stall ? (cyc % 3 == 2) : 1'b1;
            if (out_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    checks++;
                    if (cyc != 2) begin errors++; $display("FAIL %s_latency: got %0d cycles expected 2", name, cyc); end
                end
                ew = expw[16*lane +: 16];
                checks++;
                if (out_bf16 !== ew || out_lane !== LANE_W'(lane) || out_last !== 1'(lane == 3)) begin
                    errors++;
                    $display("FAIL %s_lane%0d: got bf16=%h lane=%0d last=%b expected bf16=%h lane=%0d last=%b",
                             name, lane, out_bf16, out_lane, out_last, ew, lane, (lane == 3));
                end
                checks++;
                if (acc_ready !== 1'(lane == 3) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_lane%0d: got acc_ready=%b busy=%b expected acc_ready=%b busy=1",
                             name, lane, acc_ready, busy, (lane == 3));
                end
                if (out_ready) lane++;
            end else begin
                checks++;
                if (cyc != 1 || acc_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_gap: no valid at cycle %0d, acc_ready=%b busy=%b expected only at cycle 1 with 0/1",
                             name, cyc, acc_ready, busy);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (lane != 4) begin errors++; $display("FAIL %s_timeout: got %0d lanes expected 4", name, lane); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: got valid=%b busy=%b acc_ready=%b expected 0 0 1", name, out_valid, busy, acc_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [71:0] bank_a;
        logic [71:0] bank_b;
        logic [15:0] expq [8];
        int cyc, k, hs;
        int hs_cyc [2];
        int l0a, l3a, l0b;
        bank_a = pack_bank(256, -384, 0, 128);
        bank_b = pack_bank(-256, 512, 3, -1000);
        for (int i = 0; i < 4; i++) begin
            expq[i]     = ref_bf16(lane_val(bank_a, i));
            expq[i + 4] = ref_bf16(lane_val(bank_b, i));
        end
        cyc = 0; k = 0; hs = 0; l0a = -1; l3a = -1; l0b = -1;
        hs_cyc[0] = -1; hs_cyc[1] = -1;
        out_ready = 1'b1;
        while (k < 8 && cyc < 40) begin
            acc_valid = (hs < 2);
            acc_data  = (hs == 0) ? bank_a : bank_b;
            if (out_valid) begin
                checks++;
                if (out_bf16 !== expq[k] || out_lane !== LANE_W'(k % 4) || out_last !== 1'(k % 4 == 3)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got bf16=%h lane=%0d last=%b expected bf16=%h lane=%0d last=%b",
                             k, out_bf16, out_lane, out_last, expq[k], k % 4, (k % 4 == 3));
                end
                if (k == 0) l0a = cyc;
                if (k == 3) l3a = cyc;
                if (k == 4) l0b = cyc;
                k++;
            end
            if (acc_valid && acc_ready && hs < 2) begin
                hs_cyc[hs] = cyc;
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        acc_valid = 1'b0;
        checks++;
        if (k != 8) begin errors++; $display("FAIL b2b_count: got %0d results expected 8", k); end
        checks++;
        if (l0a != hs_cyc[0] + 2) begin errors++; $display("FAIL b2b_first_latency: got cycle %0d expected %0d", l0a, hs_cyc[0] + 2); end
        checks++;
        if (hs_cyc[1] != l3a) begin errors++; $display("FAIL b2b_second_accept: got cycle %0d expected %0d", hs_cyc[1], l3a); end
        checks++;
        if (l0b != hs_cyc[1] + 2) begin errors++; $display("FAIL b2b_second_latency: got cycle %0d expected %0d", l0b, hs_cyc[1] + 2); end
    endtask

    task automatic test_reset_mid_drain();
        int n;
        logic [71:0] bank;
        logic [63:0] expw;
        @(negedge clk);
        acc_data  = pack_bank(256, -384, 0, 128);
        acc_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        n = 0;
        while (!(out_valid === 1'b1 && out_lane === 2'd1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin errors++; $display("FAIL rst_mid_wait: lane 1 not seen within %0d cycles", n); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got valid=%b acc_ready=%b busy=%b expected 0 1 0", out_valid, acc_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        bank = pack_bank(-256, 512, 3, -1000);
        for (int i = 0; i < 4; i++) expw[16*i +: 16] = ref_bf16(lane_val(bank, i));
        test_single_bank("after_rst", bank, expw, 1'b0);
    endtask

    // Random banks and backpressure against a queue-based scoreboard.
    task automatic test_random(input int n_banks);
        logic [18:0] q [$];
        logic [18:0] got;
        logic [18:0] prev;
        logic        prev_stall;
        logic [71:0] bank;
        logic [17:0] v;
        int unsigned r;
        int sent, cyc, pend;
        sent = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
        acc_valid = 1'b0;
        while ((sent < n_banks || q.size() != 0) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            got = {out_bf16, out_lane, out_last};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL rand_hold: got valid=%b word=%h expected 1 %h", out_valid, got, prev);
                end
            end
            pend = q.size() - (out_valid ? 1 : 0);
            checks++;
            if (acc_ready !== 1'(pend == 0) || busy !== 1'(out_valid || pend > 0)) begin
                errors++;
                $display("FAIL rand_status: got acc_ready=%b busy=%b expected %b %b",
                         acc_ready, busy, (pend == 0), (out_valid || pend > 0));
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got word %h expected no valid", got);
                end else if (got !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data: got %h expected %h", got, q[0]);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n_banks && $urandom_range(0, 9) < 7) begin
                for (int i = 0; i < 4; i++) begin
                    r = $urandom();
                    case ($urandom_range(0, 7))
                        0: v = 18'h00000;
                        1: v = 18'h20000;
                        2: v = 18'h1FFFF;
                        3: v = 18'h3FFFF;
                        4: v = 18'(r[7:0]);
                        default: v = r[17:0];
                    endcase
                    bank[18*i +: 18] = v;
                end
                acc_data  = bank;
                acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (acc_valid && acc_ready) begin
                for (int i = 0; i < 4; i++) begin
                    q.push_back({ref_bf16(lane_val(acc_data, i)), LANE_W'(i), 1'(i == 3)});
                end
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = got;
        end
        acc_valid = 1'b0;
        checks++;
        if (q.size() != 0 || sent != n_banks) begin
            errors++;
            $display("FAIL rand_complete: got sent=%0d pending=%0d expected sent=%0d pending=0", sent, q.size(), n_banks);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_single_bank("basic", pack_bank(256, -384, 0, 128), 64'h3F00_0000_BFC0_3F80, 1'b0);
        test_single_bank("extremes", pack_bank(131071, -131072, 1, -1), 64'hBB80_3B80_C400_43FF, 1'b0);
        test_single_bank("stall", pack_bank(256, -384, 0, 128), 64'h3F00_0000_BFC0_3F80, 1'b1);
        test_back_to_back();
        test_reset_mid_drain();
        test_random(4000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
